// File: rtl/issue_scheduler.sv
// issue_scheduler
//   Dependency-tracking issue scheduler for the instruction buffer. Allocates
//   buffer slots to incoming instructions, stores one dependency row per slot,
//   offers ready slots for issue in round-robin order and retires slots on
//   completion, clearing the finished slot's column in every row.
//
// Ports
//   clk             clock; all state updates on the rising edge
//   rst             synchronous active-high reset
//   alloc_valid     new instruction presented this cycle
//   alloc_dep       dependency vector of the new instruction (bit k = waits on slot k)
//   alloc_ready     at least one free slot exists
//   alloc_index     lowest free slot; also used as the tracking table's buffer_index
//   issue_valid     at least one slot is ready to issue
//   issue_index     slot currently offered for issue
//   issue_ready     downstream accepts the offered slot
//   complete_valid  an issued instruction has finished
//   complete_index  slot that finished
//   occupancy       number of valid slots (0..bs)
//   err             sticky flag for an illegal completion; cleared only by reset

module issue_scheduler #(
   parameter int unsigned  bs = 16,
   localparam int unsigned IW = $clog2(bs)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alloc_valid,
   input  logic [bs-1:0] alloc_dep,
   output logic          alloc_ready,
   output logic [IW-1:0] alloc_index,
   output logic          issue_valid,
   output logic [IW-1:0] issue_index,
   input  logic          issue_ready,
   input  logic          complete_valid,
   input  logic [IW-1:0] complete_index,
   output logic [IW:0]   occupancy,
   output logic          err
);

   localparam logic [bs-1:0] Lsb = {{(bs-1){1'b0}}, 1'b1};

   // Per-slot state
   logic [bs-1:0]          valid_q, valid_d;
   logic [bs-1:0]          issued_q, issued_d;
   logic [bs-1:0][bs-1:0]  dep_q, dep_d;

   // Round-robin start point and sticky error
   logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
   logic                   err_q, err_d;

   // An offer that was not accepted is latched so the index cannot move while
   // downstream is stalled (a lower slot in scan order may become ready meanwhile).
   logic                   hold_q, hold_d;
   logic [IW-1:0]          hold_idx_q, hold_idx_d;

   logic [bs-1:0]          ready;
   logic [IW-1:0]          scan_idx;
   logic [IW-1:0]          cand;
   logic                   found;

   logic                   alloc_fire;
   logic                   issue_fire;
   logic                   complete_ok;
   logic [bs-1:0]          complete_bit;
   logic [bs-1:0]          alloc_bit;

   // ---------------------------------------------------------------------
   // Readiness: valid, not yet issued, and no outstanding dependencies.
   // ---------------------------------------------------------------------
   always_comb begin
      ready = '0;
      for (int s = 0; s < int'(bs); s++) begin
         ready[s] = valid_q[s] & ~issued_q[s] & ~(|dep_q[s]);
      end
   end

   // ---------------------------------------------------------------------
   // Allocation: lowest free slot, from registered state only.
   // ---------------------------------------------------------------------
   always_comb begin
      alloc_ready = ~(&valid_q);
      alloc_index = '0;
      for (int s = int'(bs) - 1; s >= 0; s--) begin
         if (!valid_q[s]) begin
            alloc_index = IW'(s);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Issue selection: first ready slot at or after rr_ptr, wrapping.
   // ---------------------------------------------------------------------
   always_comb begin
      scan_idx = '0;
      cand     = '0;
      found    = 1'b0;
      for (int i = 0; i < int'(bs); i++) begin
         cand = rr_ptr_q + IW'(i);
         if (!found && ready[cand]) begin
            scan_idx = cand;
            found    = 1'b1;
         end
      end
   end

   // A held slot stays ready: only issue or reset can take readiness away from
   // it, since completion of an unissued slot is rejected.
   always_comb begin
      issue_valid = |ready;
      issue_index = '0;
      if (issue_valid) begin
         issue_index = hold_q ? hold_idx_q : scan_idx;
      end
   end

   // ---------------------------------------------------------------------
   // Event qualification
   // ---------------------------------------------------------------------
   always_comb begin
      alloc_fire   = alloc_valid & alloc_ready;
      issue_fire   = issue_valid & issue_ready;
      complete_ok  = complete_valid & valid_q[complete_index] & issued_q[complete_index];
      complete_bit = complete_ok ? (Lsb << complete_index) : '0;
      alloc_bit    = Lsb << alloc_index;
   end

   // ---------------------------------------------------------------------
   // Next state. Alloc, issue and complete always hit distinct slots: alloc
   // picks a pre-edge free slot, and a completing slot must already be issued.
   // ---------------------------------------------------------------------
   always_comb begin
      valid_d    = valid_q;
      issued_d   = issued_q;
      dep_d      = dep_q;
      rr_ptr_d   = rr_ptr_q;
      err_d      = err_q;
      hold_d     = issue_valid & ~issue_ready;
      hold_idx_d = issue_index;

      if (complete_valid && !complete_ok) begin
         err_d = 1'b1;
      end

      if (issue_fire) begin
         issued_d[issue_index] = 1'b1;
         rr_ptr_d              = issue_index + IW'(1);
      end

      if (complete_ok) begin
         for (int r = 0; r < int'(bs); r++) begin
            dep_d[r][complete_index] = 1'b0;
         end
         valid_d[complete_index]  = 1'b0;
         issued_d[complete_index] = 1'b0;
         dep_d[complete_index]    = '0;
      end

      // Drop bits naming empty slots, the new slot itself, or the slot that
      // retires on this same edge.
      if (alloc_fire) begin
         valid_d[alloc_index]  = 1'b1;
         issued_d[alloc_index] = 1'b0;
         dep_d[alloc_index]    = alloc_dep & valid_q & ~alloc_bit & ~complete_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         issued_q   <= '0;
         dep_q      <= '0;
         rr_ptr_q   <= '0;
         err_q      <= 1'b0;
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
      end else begin
         valid_q    <= valid_d;
         issued_q   <= issued_d;
         dep_q      <= dep_d;
         rr_ptr_q   <= rr_ptr_d;
         err_q      <= err_d;
         hold_q     <= hold_d;
         hold_idx_q <= hold_idx_d;
      end
   end

   // ---------------------------------------------------------------------
   // Status outputs
   // ---------------------------------------------------------------------
   always_comb begin
      occupancy = (IW+1)'($countones(valid_q));
      err       = err_q;
   end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Dependency-tracking issue scheduler for the instruction buffer whose dependency vectors come from the register-tracking table.
- Allocates buffer slots to incoming instructions and supplies the slot number as that table's buffer_index.
- Holds each slot's dependency row and issues ready instructions round-robin over a valid/ready handshake.
- On completion, clears the finished slot's column in every row and frees the slot.

Parameters:
bs, 16, number of buffer slots; power of two, >= 2
IW, $clog2(bs), slot index width (derived; not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
alloc_valid  input  1  new instruction presented this cycle
alloc_dep  input  bs  dependency vector for the new instruction; bit k = depends on slot k
alloc_ready  output  1  a free slot exists
alloc_index  output  IW  slot to be allocated; also drives the table's buffer_index
issue_valid  output  1  at least one slot is ready to issue
issue_index  output  IW  slot being offered for issue
issue_ready  input  1  downstream accepts the offered slot
complete_valid  input  1  an issued instruction has finished
complete_index  input  IW  slot that finished
occupancy  output  IW+1  number of valid slots
err  output  1  sticky protocol-error flag

Behaviour:
- State per slot s: valid[s], issued[s], dep[s][bs-1:0]; plus rr_ptr (IW bits) and err.
- Reset (rst high at posedge):
  - all valid, issued and dep cleared; rr_ptr=0; err=0.
  - Outputs after reset: alloc_ready=1, alloc_index=0, issue_valid=0, issue_index=0, occupancy=0, err=0.
  - Reset mid-operation discards all entries, with no completion side effects.
- Allocation:
  - alloc_ready = any slot with valid=0.
  - alloc_index = lowest-numbered slot with valid=0; 0 when none is free.
  - Both are combinational from registered state only, so a slot freed this cycle is not allocatable until next cycle.
  - Accept when alloc_valid & alloc_ready: valid=1, issued=0, dep = alloc_dep & valid_q & ~self_bit & ~completing_bit.
  - Bits pointing at empty slots, at itself, or at the slot completing this same cycle are dropped.
  - alloc_valid while alloc_ready=0: ignored; no state change and no error.
- Ready:
  - ready[s] = valid & ~issued & (dep[s]==0), evaluated on registered state.
  - An allocated instruction with no dependencies is visible as ready in the cycle after allocation.
- Issue:
  - issue_valid = |ready.
  - issue_index = first ready slot scanning upward from rr_ptr, wrapping bs-1 -> 0.
  - When issue_valid=0, issue_index=0.
  - On issue_valid & issue_ready: issued[issue_index]=1; rr_ptr = issue_index+1 mod bs.
  - issue_index must stay stable while issue_valid=1 and issue_ready=0, unless the offered slot is removed by reset.
- Completion:
  - Legal when complete_valid and slot complete_index has valid=1 and issued=1.
  - Effect: valid=0, issued=0, dep row cleared; column complete_index cleared in every other row, all in the same edge.
  - Dependents become ready in the following cycle.
  - Illegal completion (slot not valid or not issued): no state change; err=1 until reset.
- Simultaneous events:
  - Alloc, issue and complete in one cycle all take effect.
  - Complete cannot target the slot being issued: issued=0 makes it illegal and sets err.
  - Alloc never targets the completing slot, because alloc_index uses the pre-edge valid.
- occupancy: popcount of valid, registered state; range 0..bs.
- Full: occupancy==bs gives alloc_ready=0.
- Empty: issue_valid=0.

Test Plan:
- Reset, bs=4 → alloc_ready=1, alloc_index=0, issue_valid=0, occupancy=0, err=0.
- Alloc A (dep 0000), then B (dep 0001) → A in slot 0, B in slot 1; next cycle issue_valid=1, issue_index=0. Hold issue_ready=0 for 3 cycles → index stays 0. Accept, complete slot 0 → next cycle issue_index=1.
- Fill 4 slots, no deps → alloc_ready=0, occupancy=4; with issue_ready=1 constant, issue order 0,1,2,3. Complete slot 2 → next cycle alloc_ready=1, alloc_index=2.
- Alloc with alloc_dep=1111 into slot 0 of an empty buffer → dep stored as 0000 and slot ready next cycle. Alloc depending on slot 1 while slot 1 completes that cycle → new entry ready next cycle.
- complete_index=3 while slot 3 is not issued → no state change, err=1 and held; rst → err=0.
- Mid-operation rst with 3 occupied slots and issue pending → next cycle occupancy=0, issue_valid=0, alloc_index=0.
